// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one slow_memory line port between the I-cache and D-cache miss ports.
//   One line transaction is in flight at a time. The memory-side request is
//   registered at grant time and held until the memory answers; the memory's
//   ready pulse is forwarded combinationally to the owning client, and the read
//   line is broadcast to both clients (each qualifies it with its own ready).
//   After every completion one GAP cycle lets the client drop its request
//   before the next arbitration. Completed transactions are counted per client
//   with saturating counters.
//
// Parameters
//   ADDR_W  line address width (byte address bits [31:4])
//   DATA_W  line data width
//   POLICY  0 = round-robin between I and D, 1 = fixed priority with D winning
//   CNT_W   width of the saturating transaction counters
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata  I-cache request, held until i_ready
//   i_rdata, i_ready            line and one-cycle completion pulse to I-cache
//   d_*                         same set for the D-cache
//   mem_read/mem_write/mem_addr/mem_wdata  registered request to slow_memory
//   mem_rdata, mem_ready        line and one-cycle completion pulse from slow_memory
//   stat_i_cnt, stat_d_cnt      completed I / D transactions, saturating
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned POLICY = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [CNT_W-1:0]  stat_i_cnt,
    output logic [CNT_W-1:0]  stat_d_cnt
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StGap} state_t;

    state_t state;
    logic   last_d;     // 1 when the most recent grant went to the D-cache
    logic   req_i;
    logic   req_d;
    logic   pick_d;     // arbitration result, meaningful only when a request is present

    always_comb begin
        req_i = i_read | i_write;
        req_d = d_read | d_write;
        if (req_i && req_d) begin
            // Round-robin hands the contested slot to whoever did not win last time
            pick_d = (POLICY != 0) ? 1'b1 : ~last_d;
        end else begin
            pick_d = req_d;
        end
    end

    // Ready is only forwarded while the owning transaction is outstanding, so a
    // stray mem_ready in IDLE or GAP never reaches a client.
    assign i_ready = (state == StBusyI) && mem_ready;
    assign d_ready = (state == StBusyD) && mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            last_d     <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            stat_i_cnt <= '0;
            stat_d_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_i || req_d) begin
                        if (pick_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_write <= d_write;
                            mem_read  <= d_read & ~d_write;  // write wins if both set
                            last_d    <= 1'b1;
                            state     <= StBusyD;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                            mem_write <= i_write;
                            mem_read  <= i_read & ~i_write;
                            last_d    <= 1'b0;
                            state     <= StBusyI;
                        end
                    end
                end
                StBusyI: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (stat_i_cnt != '1) begin
                            stat_i_cnt <= stat_i_cnt + CNT_W'(1);
                        end
                        state <= StGap;
                    end
                end
                StBusyD: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (stat_d_cnt != '1) begin
                            stat_d_cnt <= stat_d_cnt + CNT_W'(1);
                        end
                        state <= StGap;
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
